// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle sequencer and the shared datapath
// master = sequencer side (takes instr/EQ/mem_ready, drives selects, strobes and status)
// slave  = datapath side (mirror image)
interface multicycle_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] instr;
   logic                  EQ;
   logic                  mem_ready;
   logic                  PCWrite;
   logic                  IRWrite;
   logic                  AdrSrc;
   logic                  MemRead;
   logic                  MemWrite;
   logic                  RegWrite;
   logic [1:0]            ResultSrc;
   logic [1:0]            ALUSrcA;
   logic [1:0]            ALUSrcB;
   logic [3:0]            ALUctrl;
   logic [2:0]            ImmSrc;
   logic                  retired;
   logic                  halted;
   logic                  illegal;

   modport master (
      input  instr, EQ, mem_ready,
      output PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, retired, halted, illegal
   );

   modport slave (
      output instr, EQ, mem_ready,
      input  PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, retired, halted, illegal
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer time-sharing one ALU and one memory port
// clk, rst   : core clock, synchronous active-high reset (forces FETCH, abandons any access)
// bus_io     : instr/EQ/mem_ready in; PC/IR write strobes, memory strobes, mux selects,
//              ALUctrl, ImmSrc, retired pulse and sticky halted/illegal status out
module multicycle_ctrl #(
   parameter int         DATA_WIDTH  = 32,
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input logic               clk,
   input logic               rst,
   multicycle_ctrl_if.master bus_io
);
   localparam logic [3:0] FETCH    = RESET_STATE;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] EXECI    = 4'd7;
   localparam logic [3:0] LUI      = 4'd8;
   localparam logic [3:0] AUIPC    = 4'd9;
   localparam logic [3:0] ALUWB    = 4'd10;
   localparam logic [3:0] BRANCH   = 4'd11;
   localparam logic [3:0] JAL      = 4'd12;
   localparam logic [3:0] JALR     = 4'd13;
   localparam logic [3:0] HALT     = 4'd14;
   localparam logic [3:0] TRAP     = 4'd15;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_PASS = 4'b1000;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   logic [3:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] instr_w;
   logic [6:0]            opcode, funct7;
   logic [2:0]            funct3;
   logic                  eq, mem_ready;
   logic [3:0]            alu_op, br_op;
   logic [2:0]            dec_imm;
   logic                  shift_f3, r_bad, br_bad, taken, unused_ir;
   logic                  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
   logic [1:0]            result_src, alu_src_a, alu_src_b;
   logic [3:0]            alu_ctrl;
   logic [2:0]            imm_src;
   logic                  retired, halted, illegal;

   assign instr_w   = bus_io.instr;
   assign eq        = bus_io.EQ;
   assign mem_ready = bus_io.mem_ready;
   assign opcode    = instr_w[6:0];
   assign funct3    = instr_w[14:12];
   assign funct7    = instr_w[31:25];
   assign unused_ir = ^{instr_w[24:15], instr_w[11:7]};

   // sub is only an R-type option; addi ignores bit 30
   assign alu_op = funct3 == 3'b000 ? ((state_q == EXECR && funct7[5]) ? ALU_SUB : ALU_ADD) :
                   funct3 == 3'b010 ? ALU_SLT  :
                   funct3 == 3'b011 ? ALU_SLTU :
                   funct3 == 3'b100 ? ALU_XOR  :
                   funct3 == 3'b110 ? ALU_OR   :
                   funct3 == 3'b111 ? ALU_AND  : ALU_ADD;
   assign shift_f3 = funct3 == 3'b001 || funct3 == 3'b101;
   assign r_bad    = shift_f3 || !(funct7 == 7'h00 || funct7 == 7'h20);
   assign br_op    = !funct3[2] ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT;
   assign br_bad   = funct3[2:1] == 2'b01;
   // beq/bge/bgeu take on EQ=1, bne/blt/bltu on EQ=0: bit0 xor bit2 inverts the sense
   assign taken    = eq ^ funct3[0] ^ funct3[2];
   assign dec_imm  = opcode == OP_STORE ? IMM_S :
                     opcode == OP_BR ? IMM_B :
                     (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
                     opcode == OP_JAL ? IMM_J : IMM_I;

   always_ff @(posedge clk) begin
      state_q <= rst ? RESET_STATE : state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = mem_ready ? DECODE : FETCH;
         DECODE:   state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? MEMADR :
                             opcode == OP_R ? EXECR :
                             opcode == OP_I ? EXECI :
                             opcode == OP_LUI ? LUI :
                             opcode == OP_AUIPC ? AUIPC :
                             opcode == OP_BR ? BRANCH :
                             opcode == OP_JAL ? JAL :
                             opcode == OP_JALR ? JALR :
                             opcode == OP_SYS ? HALT : TRAP;
         MEMADR:   state_d = opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
         EXECR:    state_d = r_bad ? TRAP : ALUWB;
         EXECI:    state_d = shift_f3 ? TRAP : ALUWB;
         LUI:      state_d = ALUWB;
         AUIPC:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = br_bad ? TRAP : FETCH;
         JAL:      state_d = ALUWB;
         JALR:     state_d = JAL;
         default:  state_d = state_q;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      imm_src    = IMM_I;
      retired    = 1'b0;
      halted     = 1'b0;
      illegal    = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               mem_read   = 1'b1;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               imm_src   = dec_imm;
            end
            MEMADR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               imm_src   = opcode[5] ? IMM_S : IMM_I;
            end
            MEMREAD: begin
               mem_read = 1'b1;
               adr_src  = 1'b1;
            end
            MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
               retired    = 1'b1;
            end
            MEMWRITE: begin
               mem_write = 1'b1;
               adr_src   = 1'b1;
               retired   = mem_ready;
            end
            EXECR: begin
               alu_src_a = 2'b10;
               alu_ctrl  = alu_op;
            end
            EXECI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_ctrl  = alu_op;
            end
            LUI: begin
               alu_src_b = 2'b01;
               imm_src   = IMM_U;
               alu_ctrl  = ALU_PASS;
            end
            AUIPC: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               imm_src   = IMM_U;
            end
            ALUWB: begin
               reg_write = 1'b1;
               retired   = 1'b1;
            end
            BRANCH: begin
               alu_src_a = 2'b10;
               alu_ctrl  = br_op;
               pc_write  = taken && !br_bad;
               retired   = !br_bad;
            end
            JAL: begin
               pc_write  = 1'b1;
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            HALT: halted = 1'b1;
            TRAP: begin
               halted  = 1'b1;
               illegal = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus_io.PCWrite   = pc_write;
   assign bus_io.IRWrite   = ir_write;
   assign bus_io.AdrSrc    = adr_src;
   assign bus_io.MemRead   = mem_read;
   assign bus_io.MemWrite  = mem_write;
   assign bus_io.RegWrite  = reg_write;
   assign bus_io.ResultSrc = result_src;
   assign bus_io.ALUSrcA   = alu_src_a;
   assign bus_io.ALUSrcB   = alu_src_b;
   assign bus_io.ALUctrl   = alu_ctrl;
   assign bus_io.ImmSrc    = imm_src;
   assign bus_io.retired   = retired;
   assign bus_io.halted    = halted;
   assign bus_io.illegal   = illegal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model of the sequencer checked against the DUT every cycle
module tb_multicycle_ctrl;
   typedef struct packed {
      logic       pcw, irw, mrd, mwr, rgw, ret, adr;
      logic [1:0] res, srca, srcb;
      logic [3:0] alu;
      logic [2:0] imm;
      logic       halted, illegal;
   } outs_t;
   typedef struct packed {
      logic  r, mr, eq;
      outs_t o;
   } step_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  chk = 1'b0;
   outs_t act, exp_o;
   int    checks = 0, errors = 0, ret_seen = 0;
   step_t q[$];

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.DATA_WIDTH(32)) bus ();
   multicycle_ctrl dut (.clk(clk), .rst(rst), .bus_io(bus));

   assign act = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.retired,
                 bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl, bus.ImmSrc,
                 bus.halted, bus.illegal};

   always @(negedge clk) begin
      if (chk) begin
         checks++;
         if (act.ret) ret_seen++;
         if (act !== exp_o) begin
            errors++;
            $display("FAIL cycle@%0t instr=%h: outputs got %h required %h (pcw irw mrd mwr rgw ret adr res srca srcb alu imm halted illegal)",
                     $time, bus.instr, act, exp_o);
         end
      end
   end

   task automatic lit(input string name, input int act_v, input int req_v);
      checks++;
      if (act_v != req_v) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act_v, req_v);
      end
   endtask

   task automatic push(input logic r, input logic mr, input logic eq, input outs_t o);
      step_t s;
      s = {r, mr, eq, o};
      q.push_back(s);
   endtask

   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  return sub ? 4'b0001 : 4'b0000;
         3'b010:  return 4'b0101;
         3'b011:  return 4'b0110;
         3'b100:  return 4'b0100;
         3'b110:  return 4'b0011;
         3'b111:  return 4'b0010;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic wb(input logic [1:0] res, input logic eq);
      outs_t e;
      e = '0; e.res = res; e.rgw = 1'b1; e.ret = 1'b1;
      push(1'b0, 1'b1, eq, e);
   endtask

   task automatic stop(input logic ill, input logic eq);
      outs_t e;
      e = '0; e.halted = 1'b1; e.illegal = ill;
      repeat (20) push(1'b0, 1'b1, eq, e);
   endtask

   task automatic jal_step(input logic eq);
      outs_t e;
      e = '0; e.pcw = 1'b1; e.srca = 2'b01; e.srcb = 2'b10;
      push(1'b0, 1'b1, eq, e);
   endtask

   // Expected cycle-by-cycle outputs of one instruction: fw stalled fetch cycles, mw stalled memory cycles
   task automatic model(input logic [31:0] ins, input logic eq, input int fw, input int mw);
      logic [6:0] op;
      logic [2:0] f3;
      logic       ok, tk;
      outs_t      e;
      op = ins[6:0];
      f3 = ins[14:12];
      e = '0; e.mrd = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
      repeat (fw) push(1'b0, 1'b0, eq, e);
      e.irw = 1'b1; e.pcw = 1'b1;
      push(1'b0, 1'b1, eq, e);
      e = '0; e.srca = 2'b01; e.srcb = 2'b01;
      e.imm = op == 7'b0100011 ? 3'd1 : op == 7'b1100011 ? 3'd2 :
              (op == 7'b0110111 || op == 7'b0010111) ? 3'd3 : op == 7'b1101111 ? 3'd4 : 3'd0;
      push(1'b0, 1'b1, eq, e);
      case (op)
         7'b0000011, 7'b0100011: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = op[5] ? 3'd1 : 3'd0;
            push(1'b0, 1'b1, eq, e);
            e = '0; e.adr = 1'b1;
            if (op[5]) e.mwr = 1'b1;
            else e.mrd = 1'b1;
            repeat (mw) push(1'b0, 1'b0, eq, e);
            if (op[5]) begin
               e.ret = 1'b1;
               push(1'b0, 1'b1, eq, e);
            end else begin
               push(1'b0, 1'b1, eq, e);
               wb(2'b01, eq);
            end
         end
         7'b0110011, 7'b0010011: begin
            ok = !(f3 == 3'b001 || f3 == 3'b101) && (!op[5] || ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
            e = '0; e.srca = 2'b10; e.srcb = op[5] ? 2'b00 : 2'b01; e.alu = alu_of(f3, op[5] & ins[30]);
            push(1'b0, 1'b1, eq, e);
            if (ok) wb(2'b00, eq);
            else stop(1'b1, eq);
         end
         7'b0110111: begin
            e = '0; e.srcb = 2'b01; e.imm = 3'd3; e.alu = 4'b1000;
            push(1'b0, 1'b1, eq, e);
            wb(2'b00, eq);
         end
         7'b0010111: begin
            e = '0; e.srca = 2'b01; e.srcb = 2'b01; e.imm = 3'd3;
            push(1'b0, 1'b1, eq, e);
            wb(2'b00, eq);
         end
         7'b1100011: begin
            ok = !(f3 == 3'b010 || f3 == 3'b011);
            case (f3)
               3'b000:  tk = eq;
               3'b001:  tk = !eq;
               3'b100:  tk = !eq;
               3'b101:  tk = eq;
               3'b110:  tk = !eq;
               default: tk = eq;
            endcase
            e = '0; e.srca = 2'b10; e.alu = !f3[2] ? 4'b0001 : f3[1] ? 4'b0110 : 4'b0101;
            e.pcw = ok && tk; e.ret = ok;
            push(1'b0, 1'b1, eq, e);
            if (!ok) stop(1'b1, eq);
         end
         7'b1101111: begin
            jal_step(eq);
            wb(2'b00, eq);
         end
         7'b1100111: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b01;
            push(1'b0, 1'b1, eq, e);
            jal_step(eq);
            wb(2'b00, eq);
         end
         7'b1110011: stop(1'b0, eq);
         default:    stop(1'b1, eq);
      endcase
   endtask

   task automatic play(input logic [31:0] ins);
      step_t s;
      ret_seen = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(posedge clk);
         #1;
         rst = s.r;
         bus.mem_ready = s.mr;
         bus.EQ = s.eq;
         bus.instr = ins;
         exp_o = s.o;
         chk = 1'b1;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic run(input string name, input logic [31:0] ins, input logic eq, input int fw,
                      input int mw, input int n_lit, input int ret_lit);
      model(ins, eq, fw, mw);
      lit({name, " cycles"}, q.size(), n_lit);
      play(ins);
      lit({name, " retired"}, ret_seen, ret_lit);
   endtask

   task automatic reset_cycles(input int n);
      repeat (n) push(1'b1, 1'b0, 1'b0, '0);
      play(32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      bus.instr = '0;
      bus.EQ = 1'b0;
      bus.mem_ready = 1'b0;
      reset_cycles(2);
      model(32'h002081B3, 1'b0, 0, 0);
      lit("add cycles", q.size(), 4);
      lit("add ALUctrl", int'(q[2].o.alu), 0);
      lit("add RegWrite in cycle 4", int'(q[3].o.rgw), 1);
      play(32'h002081B3);
      lit("add retired", ret_seen, 1);
      run("lw stall2", 32'h0000A103, 1'b0, 0, 2, 7, 1);
      model(32'h00208063, 1'b1, 0, 0);
      lit("beq EQ=1 PCWrite", int'(q[2].o.pcw), 1);
      play(32'h00208063);
      model(32'h00208063, 1'b0, 0, 0);
      lit("beq EQ=0 PCWrite", int'(q[2].o.pcw), 0);
      lit("beq cycles", q.size(), 3);
      play(32'h00208063);
      lit("beq retired", ret_seen, 1);
      model(32'h0020D063, 1'b1, 0, 0);
      lit("bge EQ=1 PCWrite", int'(q[2].o.pcw), 1);
      lit("bge ALUctrl", int'(q[2].o.alu), 5);
      play(32'h0020D063);
      run("bne EQ=0", 32'h00209063, 1'b0, 0, 0, 3, 1);
      run("jalr", 32'h000280E7, 1'b0, 0, 0, 5, 1);
      run("sw stalls", 32'h0020A023, 1'b0, 1, 1, 6, 1);
      run("addi", 32'h00500093, 1'b0, 0, 0, 4, 1);
      model(32'h40208133, 1'b0, 0, 0);
      lit("sub ALUctrl", int'(q[2].o.alu), 1);
      play(32'h40208133);
      run("sltu", 32'h0020B1B3, 1'b0, 0, 0, 4, 1);
      run("lui", 32'h000010B7, 1'b0, 0, 0, 4, 1);
      run("auipc", 32'h00001097, 1'b0, 0, 0, 4, 1);
      run("jal", 32'h008000EF, 1'b0, 0, 0, 4, 1);
      run("opcode 7F trap", 32'h0000007F, 1'b0, 0, 0, 22, 0);
      reset_cycles(1);
      run("sll trap", 32'h002091B3, 1'b0, 0, 0, 23, 0);
      reset_cycles(1);
      run("add after trap", 32'h002081B3, 1'b0, 0, 0, 4, 1);
      run("ecall halt", 32'h00000073, 1'b0, 0, 0, 22, 0);
      reset_cycles(1);
      model(32'h0020A023, 1'b0, 0, 1);
      void'(q.pop_back());
      push(1'b1, 1'b0, 1'b0, '0);
      lit("sw reset cycles", q.size(), 5);
      play(32'h0020A023);
      lit("sw reset retired", ret_seen, 0);
      run("add after sw reset", 32'h002081B3, 1'b0, 0, 0, 4, 1);
      chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
